// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding a single binary-to-Gray converter
// with a one-entry registered output slot.
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_bin,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_gray,
  output logic [IW-1:0]          out_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;

  slot_e            state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    id_q, id_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [IW-1:0]    win;
  logic [WIDTH-1:0] sel_bin;
  logic             found;
  logic             can_acc;
  logic             acc;

  // Search wraps naturally because N_REQ is a power of two.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[ptr_q + IW'(k)]) begin
        found = 1'b1;
        win   = ptr_q + IW'(k);
      end
    end
  end

  assign can_acc = (state_q == EMPTY) || out_ready;
  assign acc     = rst_n && can_acc && found;
  assign sel_bin = req_bin[win*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (acc) begin
      req_ready[win] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gray_d  = gray_q;
    id_d    = id_q;
    if (acc) begin
      state_d = FULL;
      gray_d  = sel_bin ^ (sel_bin >> 1);
      id_d    = win;
      ptr_d   = win + IW'(1);
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      gray_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gray_q  <= gray_d;
      id_q    <= id_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_gray  = gray_q;
  assign out_id    = id_q;

endmodule
